// File: rtl/xgs_spi_responder.sv
// xgs_spi_responder: SPI mode-0 slave emulating the XGS sensor register port.
// SPI pins are oversampled in the sys_clk domain. A frame is a 16-bit header
// ({byte_addr[14:0], rd}) followed by 16-bit data words with auto-increment.
// Ports:
//   sys_clk, sys_reset_n        : system clock, async active-low reset
//   spi_sclk/cs_n/sdout         : SPI inputs from the master (asynchronous)
//   spi_sdin, spi_sdin_oe       : read data to the master and its enable
//   reg_wr_valid/addr/data      : one-cycle mirror of every accepted write
//   addr_err, addr_err_clr      : sticky out-of-range flag and its clear
//   frame_cnt                   : number of frames whose header completed
module xgs_spi_responder #(
    parameter logic [14:0] BASE_ADDR = 15'h3000,
    parameter int unsigned REG_DEPTH = 64,
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        sys_clk,
    input  logic        sys_reset_n,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_sdout,
    output logic        spi_sdin,
    output logic        spi_sdin_oe,
    output logic        reg_wr_valid,
    output logic [14:0] reg_wr_addr,
    output logic [15:0] reg_wr_data,
    output logic        addr_err,
    input  logic        addr_err_clr,
    output logic [15:0] frame_cnt
);

    localparam int unsigned IDX_W     = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam int unsigned LAST_ADDR = 32'(BASE_ADDR) + 2 * REG_DEPTH - 2;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_WDATA, S_RDATA} state_t;

    function automatic logic in_range(input logic [14:0] a);
        return (32'(a) >= 32'(BASE_ADDR)) && (32'(a) <= LAST_ADDR);
    endfunction

    function automatic logic [IDX_W-1:0] reg_idx(input logic [14:0] a);
        logic [14:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> 1);
    endfunction

    state_t      r_state, w_state_next;
    logic [2:0]  r_sclk_sync, r_cs_sync;     // [1] synchronised, [2] previous
    logic [1:0]  r_sdo_sync;
    logic [3:0]  r_bit_cnt, r_fall_cnt;
    logic [14:0] r_shift_in, r_addr;
    logic [15:0] r_shift_out, r_frame_cnt, r_wr_data;
    logic [14:0] r_wr_addr;
    logic        r_hdr_seen, r_rd_started, r_sdin, r_sdin_oe, r_wr_valid, r_addr_err;
    logic [15:0] r_mem [REG_DEPTH];

    logic        w_cs_fall, w_cs_rise, w_rise, w_fall, w_sdo, w_last_bit;
    logic        w_hdr_done, w_wr_word, w_rd_fall, w_abort, w_rd_load, w_err_set;
    logic [15:0] w_word, w_hdr_rd, w_next_rd;
    logic [14:0] w_hdr_addr, w_addr_next;

    // Pin synchronisers; CS resets to its idle (high) level
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_sdo_sync  <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], spi_sclk};
            r_cs_sync   <= {r_cs_sync[1:0], spi_cs_n};
            r_sdo_sync  <= {r_sdo_sync[0], spi_sdout};
        end
    end

    // Edge detection; SCLK edges are qualified by an asserted chip select
    assign w_cs_fall  = r_cs_sync[2] & ~r_cs_sync[1];
    assign w_cs_rise  = ~r_cs_sync[2] & r_cs_sync[1];
    assign w_rise     = ~r_cs_sync[1] & r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_fall     = ~r_cs_sync[1] & ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_sdo      = r_sdo_sync[1];
    assign w_last_bit = (r_bit_cnt == 4'd15);
    assign w_word     = {r_shift_in, w_sdo};
    assign w_hdr_addr = {w_word[15:2], 1'b0};
    assign w_addr_next = r_addr + 15'd2;
    assign w_hdr_rd   = in_range(w_hdr_addr)  ? r_mem[reg_idx(w_hdr_addr)]  : 16'h0000;
    assign w_next_rd  = in_range(w_addr_next) ? r_mem[reg_idx(w_addr_next)] : 16'h0000;

    // A word boundary on the read side is the 16th fall after the first one
    assign w_rd_load  = w_rd_fall & r_rd_started & (r_fall_cnt == 4'd0);
    assign w_err_set  = (w_wr_word & ~in_range(r_addr))
                      | (w_hdr_done & w_word[0] & ~in_range(w_hdr_addr))
                      | (w_rd_load & ~in_range(w_addr_next));

    // FSM state register
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) r_state <= S_IDLE;
        else              r_state <= w_state_next;
    end

    // FSM next state and per-cycle control strobes; CS rising overrides all
    always_comb begin
        w_state_next = r_state;
        w_hdr_done   = 1'b0;
        w_wr_word    = 1'b0;
        w_rd_fall    = 1'b0;
        w_abort      = 1'b0;
        if (w_cs_rise) begin
            w_state_next = S_IDLE;
            w_abort      = 1'b1;
        end else begin
            case (r_state)
                S_IDLE:  if (w_cs_fall) w_state_next = S_HDR;
                S_HDR: begin
                    if (w_rise && w_last_bit) begin
                        w_hdr_done   = 1'b1;
                        w_state_next = w_word[0] ? S_RDATA : S_WDATA;
                    end
                end
                S_WDATA: if (w_rise && w_last_bit) w_wr_word = 1'b1;
                S_RDATA: if (w_fall) w_rd_fall = 1'b1;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Datapath: shifting, register file, read serialiser and status
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_bit_cnt    <= '0;
            r_fall_cnt   <= '0;
            r_shift_in   <= '0;
            r_shift_out  <= '0;
            r_addr       <= '0;
            r_hdr_seen   <= 1'b0;
            r_rd_started <= 1'b0;
            r_sdin       <= 1'b0;
            r_sdin_oe    <= 1'b0;
            r_wr_valid   <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_addr_err   <= 1'b0;
            r_frame_cnt  <= '0;
            for (int i = 0; i < int'(REG_DEPTH); i++) r_mem[i] <= RESET_VAL;
        end else begin
            r_wr_valid <= 1'b0;
            if (r_state == S_IDLE) begin
                r_bit_cnt  <= '0;
                r_hdr_seen <= 1'b0;
            end else if (w_rise) begin
                r_bit_cnt  <= r_bit_cnt + 4'd1;
                r_shift_in <= {r_shift_in[13:0], w_sdo};
            end

            if (w_hdr_done) begin
                r_addr     <= w_hdr_addr;
                r_hdr_seen <= 1'b1;
                if (w_word[0]) begin
                    r_shift_out  <= w_hdr_rd;
                    r_sdin_oe    <= 1'b1;
                    r_rd_started <= 1'b0;
                    r_fall_cnt   <= '0;
                end
            end

            if (w_wr_word) begin
                if (in_range(r_addr)) begin
                    r_mem[reg_idx(r_addr)] <= w_word;
                    r_wr_valid <= 1'b1;
                    r_wr_addr  <= r_addr;
                    r_wr_data  <= w_word;
                end
                r_addr <= w_addr_next;
            end

            if (w_rd_fall) begin
                r_fall_cnt   <= r_fall_cnt + 4'd1;
                r_rd_started <= 1'b1;
                if (w_rd_load) begin
                    r_addr      <= w_addr_next;
                    r_sdin      <= w_next_rd[15];
                    r_shift_out <= {w_next_rd[14:0], 1'b0};
                end else begin
                    r_sdin      <= r_shift_out[15];
                    r_shift_out <= {r_shift_out[14:0], 1'b0};
                end
            end

            if (w_abort) begin
                r_sdin    <= 1'b0;
                r_sdin_oe <= 1'b0;
                if (r_hdr_seen) r_frame_cnt <= r_frame_cnt + 16'd1;
            end

            // Set wins over clear
            r_addr_err <= w_err_set | (r_addr_err & ~addr_err_clr);
        end
    end

    assign spi_sdin     = r_sdin;
    assign spi_sdin_oe  = r_sdin_oe;
    assign reg_wr_valid = r_wr_valid;
    assign reg_wr_addr  = r_wr_addr;
    assign reg_wr_data  = r_wr_data;
    assign addr_err     = r_addr_err;
    assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_xgs_spi_responder.sv
// Testbench for xgs_spi_responder: drives SPI mode-0 frames as the master,
// keeps a reference register file, and scores strobes and read words.
module tb_xgs_spi_responder;

    localparam logic [14:0] BASE  = 15'h3000;
    localparam int          DEPTH = 64;
    localparam logic [15:0] RV    = 16'h0000;
    localparam int          HALF  = 40;

    logic        sys_clk = 1'b0;
    logic        sys_reset_n = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_sdout = 1'b0;
    logic        spi_sdin, spi_sdin_oe, reg_wr_valid, addr_err;
    logic        addr_err_clr = 1'b0;
    logic [14:0] reg_wr_addr;
    logic [15:0] reg_wr_data, frame_cnt;

    xgs_spi_responder #(.BASE_ADDR(BASE), .REG_DEPTH(DEPTH), .RESET_VAL(RV)) dut (
        .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_sdout(spi_sdout),
        .spi_sdin(spi_sdin), .spi_sdin_oe(spi_sdin_oe),
        .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .addr_err(addr_err), .addr_err_clr(addr_err_clr), .frame_cnt(frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [30:0] wr_q[$];
    logic [15:0] rd_q[$];
    logic [15:0] tx_q[$];
    logic [15:0] m_mem [DEPTH];
    logic [15:0] m_frames;
    logic        m_err;
    logic [15:0] rd_sh;
    int          rd_n;

    function automatic bit m_in(input logic [14:0] a);
        return (int'(a) >= int'(BASE)) && (int'(a) <= int'(BASE) + 2 * DEPTH - 2);
    endfunction

    function automatic int m_idx(input logic [14:0] a);
        return (int'(a) - int'(BASE)) / 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = RV;
        m_frames = '0;
        m_err    = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_sdin"}, 32'(spi_sdin), 0);
        chk({tag, "_oe"}, 32'(spi_sdin_oe), 0);
        chk({tag, "_wr_valid"}, 32'(reg_wr_valid), 0);
        chk({tag, "_wr_addr"}, 32'(reg_wr_addr), 0);
        chk({tag, "_wr_data"}, 32'(reg_wr_data), 0);
        chk({tag, "_addr_err"}, 32'(addr_err), 0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    endtask

    // Shift the top n bits of tx, MSB first; data changes while SCLK is low
    task automatic sclk_bits(input logic [15:0] tx, input int n);
        for (int i = 0; i < n; i++) begin
            spi_sdout = tx[15-i];
            #(HALF);
            spi_sclk = 1'b1;
            #(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic frame_start;
        @(negedge sys_clk);
        spi_cs_n = 1'b0;
        #(HALF);
    endtask

    task automatic frame_end;
        #(HALF);
        spi_cs_n  = 1'b1;
        spi_sdout = 1'b0;
        #(3 * HALF);
    endtask

    task automatic post_check(input string tag);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(m_frames));
        chk({tag, "_addr_err"}, 32'(addr_err), 32'(m_err));
        chk({tag, "_oe_idle"}, 32'(spi_sdin_oe), 0);
        chk({tag, "_sdin_idle"}, 32'(spi_sdin), 0);
    endtask

    // Write frame at byte address a with the words queued in tx_q
    task automatic do_write(input logic [14:0] a);
        logic [14:0] cur;
        logic [15:0] d;
        cur = {a[14:1], 1'b0};
        frame_start;
        sclk_bits({a, 1'b0}, 16);
        while (tx_q.size() > 0) begin
            d = tx_q.pop_front();
            if (m_in(cur)) begin
                m_mem[m_idx(cur)] = d;
                wr_q.push_back({cur, d});
            end else begin
                m_err = 1'b1;
            end
            sclk_bits(d, 16);
            cur = cur + 15'd2;
        end
        frame_end;
        m_frames++;
        post_check("write");
    endtask

    // Read frame of n words; the header and each finished word fetch the next address
    task automatic do_read(input logic [14:0] a, input int n);
        logic [14:0] cur;
        cur = {a[14:1], 1'b0};
        frame_start;
        sclk_bits({a, 1'b1}, 16);
        if (!m_in(cur)) m_err = 1'b1;
        for (int k = 0; k < n; k++) begin
            rd_q.push_back(m_in(cur) ? m_mem[m_idx(cur)] : 16'h0000);
            sclk_bits(16'($urandom), 16);
            cur = cur + 15'd2;
            if (!m_in(cur)) m_err = 1'b1;
        end
        frame_end;
        m_frames++;
        post_check("read");
    endtask

    task automatic clr_err;
        @(negedge sys_clk);
        addr_err_clr = 1'b1;
        @(negedge sys_clk);
        addr_err_clr = 1'b0;
        m_err = 1'b0;
        chk("addr_err_clr", 32'(addr_err), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] a;
        int          n;
        model_reset;
        rd_n = 0;
        rd_sh = '0;

        fork
            // Write monitor: every strobe must match the oldest expected write
            forever begin
                @(negedge sys_clk);
                if (reg_wr_valid) begin
                    if (wr_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL wr_unexpected: got %0h/%0h expected no strobe",
                                 reg_wr_addr, reg_wr_data);
                    end else begin
                        chk("wr_strobe", 32'({reg_wr_addr, reg_wr_data}), 32'(wr_q.pop_front()));
                    end
                end
            end
            // Read monitor: master samples on SCLK rise while the output is enabled
            forever begin
                @(posedge spi_sclk);
                if (!spi_sdin_oe) begin
                    rd_n = 0;
                end else begin
                    rd_sh = {rd_sh[14:0], spi_sdin};
                    rd_n++;
                    if (rd_n == 16) begin
                        rd_n = 0;
                        if (rd_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL rd_unexpected: got %0h expected no word", rd_sh);
                        end else begin
                            chk("rd_word", 32'(rd_sh), 32'(rd_q.pop_front()));
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge sys_clk);
        chk_outputs_zero("reset");
        sys_reset_n = 1'b1;
        repeat (4) @(negedge sys_clk);

        // Single write and read back
        tx_q.push_back(16'hA5C3);
        do_write(15'h3000);
        do_read(15'h3000, 1);

        // Burst write and burst read back
        tx_q.push_back(16'h1111);
        tx_q.push_back(16'h2222);
        tx_q.push_back(16'h3333);
        do_write(15'h3002);
        do_read(15'h3002, 3);

        // Last register, then one past the end
        tx_q.push_back(16'hBEEF);
        tx_q.push_back(16'hDEAD);
        do_write(15'h307E);
        clr_err;

        // Aborted write: header plus 9 data bits, header still counts the frame
        frame_start;
        sclk_bits(16'h6000, 16);
        sclk_bits(16'hFFFF, 9);
        frame_end;
        m_frames++;
        post_check("abort");
        do_read(15'h3000, 1);

        // 15-bit address wrap, both words out of range
        tx_q.push_back(16'h0F0F);
        tx_q.push_back(16'hF0F0);
        do_write(15'h7FFE);
        clr_err;

        // Randomised traffic around the emulated window
        for (int it = 0; it < 40; it++) begin
            a = 15'(int'(BASE) - 4 + 2 * int'($urandom_range(0, DEPTH + 3)));
            n = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < n; k++) tx_q.push_back(16'($urandom));
                do_write(a);
            end else begin
                do_read(a, n);
            end
            if ($urandom_range(0, 3) == 0) clr_err;
        end

        // Make sure 0x3002 is non-reset before the mid-read reset
        tx_q.push_back(16'h5A5A);
        do_write(15'h3002);

        // Reset in the middle of a read data word
        frame_start;
        sclk_bits({15'h3002, 1'b1}, 16);
        sclk_bits(16'h0000, 5);
        @(negedge sys_clk);
        chk("oe_during_read", 32'(spi_sdin_oe), 1);
        #2;
        sys_reset_n = 1'b0;
        @(negedge sys_clk);
        chk_outputs_zero("midreset");
        model_reset;
        spi_cs_n  = 1'b1;
        spi_sdout = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_reset_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        do_read(15'h3002, 1);

        repeat (10) @(negedge sys_clk);
        chk("wr_queue_drained", 32'(wr_q.size()), 0);
        chk("rd_queue_drained", 32'(rd_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
